// File: rtl/simd_product_accumulator_if.sv
// Product-beat and accumulator-result bus between the SIMD multiplier, the
// segmented accumulator and the DSP writeback.
interface simd_product_accumulator_if #(
  parameter int unsigned ACC_W = 48
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [44:0]          result_0;
  logic [44:0]          result_1;
  logic [15:0]          simd_carry;
  logic [1:0]           mode;
  logic                 signed_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*ACC_W-1:0]   acc_out;
  logic [1:0]           out_mode;
  logic                 err_mode;

  modport master (
    output in_valid, in_last, result_0, result_1, simd_carry, mode, signed_en, out_ready,
    input  in_ready, out_valid, acc_out, out_mode, err_mode
  );

  modport slave (
    input  in_valid, in_last, result_0, result_1, simd_carry, mode, signed_en, out_ready,
    output in_ready, out_valid, acc_out, out_mode, err_mode
  );
endinterface

// File: rtl/simd_product_accumulator.sv
// Final segmented add of the multiplier's redundant vectors, lane split with
// sign/zero extension, and per-lane group accumulation with a valid/ready output.
module simd_product_accumulator #(
  parameter int unsigned ACC_W   = 48,
  parameter int unsigned ACC_LEN = 4
) (
  input logic                       clk,
  input logic                       reset,
  simd_product_accumulator_if.slave bus
);
  localparam int NumLanes = 8;
  localparam int SumW     = 45;
  localparam int RawW     = 47;
  localparam int Bnd [NumLanes] = '{13, 17, 23, 27, 31, 35, 41, 45};

  typedef logic [ACC_W-1:0] lane_t;
  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    grp_mode_q, grp_mode_d;
  logic          err_q;
  logic          s1_valid_q, s1_first_q;
  lane_t         s1_lane_q [NumLanes];
  lane_t         acc_q [NumLanes];
  lane_t         acc_d [NumLanes];

  logic [7:0]      active;
  logic [SumW-1:0] kill;
  logic [SumW-1:0] seg_sum;
  lane_t           lane [NumLanes];
  logic            in_ready, out_valid, handshake;
  logic            first, match, accept, take, final_beat;

  function automatic lane_t extend(logic [RawW-1:0] raw, int w, logic sgn);
    lane_t mask;
    lane_t fill;
    mask = (lane_t'(1) << w) - lane_t'(1);
    fill = {ACC_W{sgn & raw[w-1]}};
    return (lane_t'(raw) & mask) | (fill & ~mask);
  endfunction

  // Bit j set when boundary j splits lanes in this mode; boundary 7 (bit 45) always does.
  always_comb begin
    unique case (bus.mode)
      2'b00:   active = 8'b1000_0000;
      2'b01:   active = 8'b1000_1000;
      2'b10:   active = 8'b1010_1010;
      default: active = 8'b1111_1111;
    endcase
  end

  always_comb begin
    kill = '0;
    for (int j = 0; j < NumLanes - 1; j++) begin
      if (active[j]) kill[Bnd[j]] = 1'b1;
    end
  end

  always_comb begin
    logic c;
    c       = 1'b0;
    seg_sum = '0;
    for (int i = 0; i < SumW; i++) begin
      if (kill[i]) c = 1'b0;
      seg_sum[i] = bus.result_0[i] ^ bus.result_1[i] ^ c;
      c = (bus.result_0[i] & bus.result_1[i]) | (c & (bus.result_0[i] ^ bus.result_1[i]));
    end
  end

  // Each lane is its sum slice topped by the boundary's two carry bits.
  always_comb begin
    logic [RawW-1:0] raw;
    logic [2:0]      k;
    int              lo;
    int              w;
    for (int n = 0; n < NumLanes; n++) lane[n] = '0;
    raw = '0;
    k   = '0;
    lo  = 0;
    w   = 0;
    if (bus.mode == 2'b00) begin
      lane[0] = extend(RawW'(seg_sum), SumW, bus.signed_en);
    end else begin
      for (int j = 0; j < NumLanes; j++) begin
        if (active[j]) begin
          w   = Bnd[j] - lo;
          raw = RawW'(seg_sum >> lo) & ((RawW'(1) << w) - RawW'(1));
          raw = raw | (RawW'(bus.simd_carry[2*j +: 2]) << w);
          lane[k] = extend(raw, w + 2, bus.signed_en);
          lo = Bnd[j];
          k  = k + 3'd1;
        end
      end
    end
  end

  assign first      = (state_q == StIdle);
  assign match      = first | (bus.mode == grp_mode_q);
  assign accept     = bus.in_valid & in_ready;
  assign take       = accept & match;
  assign final_beat = take & (bus.in_last | (({1'b0, cnt_q} + 9'd1) == 9'(ACC_LEN)));
  assign handshake  = out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (take) state_d = final_beat ? StDrain : StAccum;
      StAccum: if (final_beat) state_d = StDrain;
      StDrain: if (handshake) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // out_valid waits for the closing beat to leave the input register.
  always_comb begin
    in_ready  = (state_q != StDrain);
    out_valid = (state_q == StDrain) & ~s1_valid_q;
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_mode  = grp_mode_q;
    bus.err_mode  = err_q;
    bus.acc_out   = '0;
    for (int k = 0; k < NumLanes; k++) bus.acc_out[k*ACC_W +: ACC_W] = acc_q[k];
  end

  always_comb begin
    cnt_d      = cnt_q;
    grp_mode_d = grp_mode_q;
    if (handshake)  cnt_d = '0;
    else if (take)  cnt_d = cnt_q + 8'd1;
    if (take && first) grp_mode_d = bus.mode;
  end

  always_comb begin
    for (int k = 0; k < NumLanes; k++) begin
      acc_d[k] = acc_q[k];
      if (s1_valid_q) acc_d[k] = s1_first_q ? s1_lane_q[k] : acc_q[k] + s1_lane_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      grp_mode_q <= 2'b00;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      for (int k = 0; k < NumLanes; k++) begin
        s1_lane_q[k] <= '0;
        acc_q[k]     <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      grp_mode_q <= grp_mode_d;
      err_q      <= accept & ~match;
      s1_valid_q <= take;
      s1_first_q <= first;
      for (int k = 0; k < NumLanes; k++) begin
        if (take) s1_lane_q[k] <= lane[k];
        acc_q[k] <= acc_d[k];
      end
    end
  end
endmodule

// File: tb/tb_simd_product_accumulator.sv
// Directed and randomized checks of simd_product_accumulator against a
// segment-arithmetic reference model.
module tb_simd_product_accumulator;
  localparam int ACC_W   = 48;
  localparam int ACC_LEN = 4;
  localparam int VW      = 8 * ACC_W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  simd_product_accumulator_if #(.ACC_W(ACC_W)) bus ();

  simd_product_accumulator #(.ACC_W(ACC_W), .ACC_LEN(ACC_LEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [ACC_W-1:0] macc [8];
  int               mcnt  = 0;
  logic [1:0]       mmode = 2'b00;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] msk(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [ACC_W-1:0] sx(logic [63:0] v, int w, bit sgn);
    logic [63:0] r;
    r = v & msk(w);
    if (sgn && r[w-1]) r = r | ~msk(w);
    return r[ACC_W-1:0];
  endfunction

  // Each lane: modular sum of its slice of r0 and r1, carry pair on top, then extended.
  function automatic logic [VW-1:0] ref_lanes(logic [44:0] r0, logic [44:0] r1,
                                              logic [15:0] c, logic [1:0] m, bit sgn);
    int bnd [8] = '{13, 17, 23, 27, 31, 35, 41, 45};
    logic [7:0]    act;
    logic [VW-1:0] v;
    logic [63:0]   seg;
    int lo, k, wd;
    v  = '0;
    lo = 0;
    k  = 0;
    act = (m == 2'd0) ? 8'h80 : (m == 2'd1) ? 8'h88 : (m == 2'd2) ? 8'hAA : 8'hFF;
    if (m == 2'd0) begin
      v[ACC_W-1:0] = sx(64'(r0) + 64'(r1), 45, sgn);
    end else begin
      for (int j = 0; j < 8; j++) begin
        if (act[j]) begin
          wd  = bnd[j] - lo;
          seg = ((64'(r0) >> lo) & msk(wd)) + ((64'(r1) >> lo) & msk(wd));
          seg = (seg & msk(wd)) | (64'(c[2*j +: 2]) << wd);
          v[k*ACC_W +: ACC_W] = sx(seg, wd + 2, sgn);
          lo = bnd[j];
          k++;
        end
      end
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] mpack();
    logic [VW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*ACC_W +: ACC_W] = macc[k];
    return v;
  endfunction

  function automatic logic [44:0] r45();
    return 45'({$urandom(), $urandom()});
  endfunction

  task automatic send(input logic [44:0] r0, input logic [44:0] r1, input logic [15:0] c,
                      input logic [1:0] m, input bit sgn, input bit last);
    int n = 0;
    bus.result_0   = r0;
    bus.result_1   = r1;
    bus.simd_carry = c;
    bus.mode       = m;
    bus.signed_en  = sgn;
    bus.in_last    = last;
    bus.in_valid   = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready wait", VW'(bus.in_ready), VW'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic beat(input logic [44:0] r0, input logic [44:0] r1, input logic [15:0] c,
                      input logic [1:0] m, input bit sgn, input bit last, output bit done);
    logic [VW-1:0] ln;
    bit err = 0;
    ln = ref_lanes(r0, r1, c, m, sgn);
    if (mcnt == 0) begin
      mmode = m;
      for (int k = 0; k < 8; k++) macc[k] = ln[k*ACC_W +: ACC_W];
      mcnt = 1;
    end else if (m != mmode) begin
      err = 1;
    end else begin
      for (int k = 0; k < 8; k++) macc[k] = macc[k] + ln[k*ACC_W +: ACC_W];
      mcnt++;
    end
    done = !err && (mcnt == ACC_LEN || last);
    send(r0, r1, c, m, sgn, last);
    chk("err_mode", VW'(bus.err_mode), VW'(err));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " out_valid"}, VW'(bus.out_valid), VW'(1));
    chk({tag, " acc_out"}, bus.acc_out, mpack());
    chk({tag, " out_mode"}, VW'(bus.out_mode), VW'(mmode));
    chk({tag, " in_ready drain"}, VW'(bus.in_ready), VW'(0));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " valid drop"}, VW'(bus.out_valid), VW'(0));
    chk({tag, " in_ready idle"}, VW'(bus.in_ready), VW'(1));
    mcnt = 0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mcnt  = 0;
    mmode = 2'b00;
    for (int k = 0; k < 8; k++) macc[k] = '0;
    chk({tag, " out_valid"}, VW'(bus.out_valid), VW'(0));
    chk({tag, " in_ready"}, VW'(bus.in_ready), VW'(1));
    chk({tag, " acc_out"}, bus.acc_out, VW'(0));
    chk({tag, " out_mode"}, VW'(bus.out_mode), VW'(0));
    chk({tag, " err_mode"}, VW'(bus.err_mode), VW'(0));
  endtask

  task automatic rand_group();
    bit         done = 0;
    int         nb   = 0;
    logic [1:0] gm   = 2'($urandom_range(0, 3));
    bit         sgn  = 1'($urandom_range(0, 1));
    logic [1:0] m;
    while (!done && nb < 40) begin
      m = gm;
      if (mcnt > 0 && $urandom_range(0, 5) == 0) m = gm ^ 2'($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      beat(r45(), r45(), 16'($urandom()), m, sgn, $urandom_range(0, 4) == 0, done);
      nb++;
    end
    drain("rand");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    logic [VW-1:0] exp_v;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.result_0   = '0;
    bus.result_1   = '0;
    bus.simd_carry = '0;
    bus.mode       = 2'b00;
    bus.signed_en  = 1'b0;
    bus.out_ready  = 1'b0;
    @(posedge clk); #1;
    do_reset("reset");

    // T1 unsigned full group and output latency.
    for (int i = 0; i < 4; i++) beat(45'd100, 45'd23, 16'h0, 2'b00, 0, 0, done);
    chk("T1 done", VW'(done), VW'(1));
    chk("T1 valid+1", VW'(bus.out_valid), VW'(0));
    @(posedge clk); #1;
    chk("T1 valid+2", VW'(bus.out_valid), VW'(1));
    exp_v = '0;
    exp_v[ACC_W-1:0] = 48'd492;
    chk("T1 const", bus.acc_out, exp_v);
    drain("T1");

    // T2 signed wrap.
    beat(45'h1FFF_FFFF_FFFF, 45'd0, 16'h0, 2'b00, 1, 0, done);
    beat(45'h1FFF_FFFF_FFFF, 45'd0, 16'h0, 2'b00, 1, 1, done);
    @(posedge clk); #1;
    exp_v = '0;
    exp_v[ACC_W-1:0] = 48'hFFFF_FFFF_FFFE;
    chk("T2 const", bus.acc_out, exp_v);
    drain("T2");

    // T3 carry kill at bit 27.
    beat(45'h7FF_FFFF, 45'd1, 16'h0040, 2'b01, 0, 1, done);
    @(posedge clk); #1;
    exp_v = '0;
    exp_v[ACC_W-1:0] = 48'h800_0000;
    chk("T3 const", bus.acc_out, exp_v);
    drain("T3");

    // T4 mode mismatch mid-group.
    beat(r45(), r45(), 16'($urandom()), 2'b11, 1, 0, done);
    beat(r45(), r45(), 16'($urandom()), 2'b10, 1, 0, done);
    @(posedge clk); #1;
    chk("T4 err pulse end", VW'(bus.err_mode), VW'(0));
    beat(r45(), r45(), 16'($urandom()), 2'b11, 1, 0, done);
    beat(r45(), r45(), 16'($urandom()), 2'b11, 1, 0, done);
    chk("T4 not done at 3", VW'(done), VW'(0));
    beat(r45(), r45(), 16'($urandom()), 2'b11, 1, 0, done);
    chk("T4 done at 4", VW'(done), VW'(1));
    drain("T4");

    // T5 back-pressure with in_valid held high.
    for (int i = 0; i < 4; i++) beat(r45(), r45(), 16'($urandom()), 2'b10, 0, 0, done);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.mode     = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("T5 in_ready", VW'(bus.in_ready), VW'(0));
      chk("T5 acc_out", bus.acc_out, mpack());
    end
    bus.in_valid = 1'b0;
    drain("T5");
    beat(r45(), r45(), 16'($urandom()), 2'b01, 1, 1, done);
    drain("T5 next");

    // T6 reset mid-group.
    beat(r45(), r45(), 16'($urandom()), 2'b11, 0, 0, done);
    beat(r45(), r45(), 16'($urandom()), 2'b11, 0, 0, done);
    do_reset("T6 reset");
    for (int i = 0; i < 4; i++) beat(r45(), r45(), 16'($urandom()), 2'b11, 0, 0, done);
    drain("T6");

    for (int g = 0; g < 25; g++) rand_group();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
